uart_timebase_store: RTL and testbench

- Timing and storage core for the matrix-result UART transmit path.
- Generates, from one system clock:
  - the UART bit clock (`bclk`) and its 8x oversampling clock (`bclk_x8`), both at the selected baud rate;
  - a slow heartbeat clock (`slow_clk`).
- Holds a ROWS x COLS matrix of bytes with a synchronous write port and a registered read port.
- Consumers are the transmitter, the edge detectors and the transmit FSM.

---
 rtl/uart_timebase_pkg.sv | 26 ++
 rtl/uart_timebase_store_toggle_div.sv | 27 ++
 rtl/uart_timebase_store.sv | 58 +++++
 tb/tb_uart_timebase_store.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_timebase_pkg.sv
// Shared constants and divider helpers for the UART timebase/storage core.
package uart_timebase_pkg;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  // Unknown select codes fall back to the slowest rate.
  function automatic int unsigned baud_of(input int sel);
    case (sel)
      1:       return BAUD_19200;
      2:       return BAUD_57600;
      3:       return BAUD_115200;
      default: return BAUD_9600;
    endcase
  endfunction

  function automatic int unsigned half_div(input int unsigned clk_hz,
                                           input int unsigned divisor);
    int unsigned q;
    q = clk_hz / divisor;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_timebase_store_toggle_div.sv
// Square-wave divider: output toggles every HALF clk cycles (period 2*HALF).
module toggle_div #(
  parameter int unsigned HALF = 1
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      out <= ~out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_timebase_store.sv
// UART bit/oversample/heartbeat clock generation plus a small byte matrix
// with a synchronous write port and a registered read port.
module uart_timebase_store
  import uart_timebase_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int          BAUD_SEL    = 0,
  parameter int unsigned SLOW_CYCLES = 100_000_000,
  parameter int          ROWS        = 2,
  parameter int          COLS        = 2,
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              bclk,
  output logic              bclk_x8,
  output logic              slow_clk,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_value,
  input  logic              read,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned BAUD = baud_of(BAUD_SEL);
  localparam int unsigned H_B  = half_div(CLK_HZ, 2 * BAUD);
  localparam int unsigned H_8  = half_div(CLK_HZ, 16 * BAUD);
  localparam int unsigned H_S  = half_div(SLOW_CYCLES, 2);

  localparam int DEPTH = ROWS * COLS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  toggle_div #(.HALF(H_B)) u_bclk (.clk(clk), .rst(rst), .out(bclk));
  toggle_div #(.HALF(H_8)) u_bclk_x8 (.clk(clk), .rst(rst), .out(bclk_x8));
  toggle_div #(.HALF(H_S)) u_slow (.clk(clk), .rst(rst), .out(slow_clk));

  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_ok;
  logic rd_ok;
  assign wr_ok = int'(write_address) < DEPTH;
  assign rd_ok = int'(read_address) < DEPTH;

  // Read and write share one block so a same-address access returns the
  // pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data <= '0;
    end else begin
      if (write && wr_ok) mem[write_address[IDX_W-1:0]] <= write_value;
      if (read) data <= rd_ok ? mem[read_address[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_uart_timebase_store.sv
// Bench for uart_timebase_store: divider timing on two configurations plus a
// vector table for the memory port, checked through an expected-data queue.
module tb_uart_timebase_store;

  logic       clk;
  logic       rst;
  logic       bclk_m, bclk_x8_m, slow_m;
  logic       bclk_f, bclk_x8_f, slow_f;
  logic       write;
  logic [5:0] write_address;
  logic [7:0] write_value;
  logic       read;
  logic [5:0] read_address;
  logic [7:0] data_m;
  logic [7:0] data_f;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       wr;
    logic [5:0] wa;
    logic [7:0] wv;
    logic       rd;
    logic [5:0] ra;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t post_rst[$];

  // Default baud, short heartbeat.
  uart_timebase_store #(.BAUD_SEL(0), .SLOW_CYCLES(10)) dut_m (
    .clk(clk), .rst(rst),
    .bclk(bclk_m), .bclk_x8(bclk_x8_m), .slow_clk(slow_m),
    .write(write), .write_address(write_address), .write_value(write_value),
    .read(read), .read_address(read_address), .data(data_m)
  );

  // 115200 baud, fastest heartbeat.
  uart_timebase_store #(.BAUD_SEL(3), .SLOW_CYCLES(2)) dut_f (
    .clk(clk), .rst(rst),
    .bclk(bclk_f), .bclk_x8(bclk_x8_f), .slow_clk(slow_f),
    .write(1'b0), .write_address(6'd0), .write_value(8'd0),
    .read(1'b0), .read_address(6'd0), .data(data_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic get_sig(input int idx);
    case (idx)
      0:       return bclk_m;
      1:       return bclk_x8_m;
      2:       return slow_m;
      3:       return bclk_f;
      4:       return bclk_x8_f;
      default: return slow_f;
    endcase
  endfunction

  function automatic vec_t mk(input logic wr, input int wa, input int wv,
                              input logic rd, input int ra, input logic chk, input int exp);
    vec_t v;
    v.wr  = wr;
    v.wa  = 6'(wa);
    v.wv  = 8'(wv);
    v.rd  = rd;
    v.ra  = 6'(ra);
    v.chk = chk;
    v.exp = 8'(exp);
    return v;
  endfunction

  // Starts right after reset release: counts edges to the first rise, then
  // the length of each following half period.
  task automatic measure(input int idx, input int h, input int halves, input string name);
    int   n;
    logic prev;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (get_sig(idx) === 1'b1) break;
      if (n > 2 * h + 10) break;
    end
    check($sformatf("%s first_rise", name), n, h);
    prev = get_sig(idx);
    for (int k = 0; k < halves; k++) begin
      n = 0;
      while (1) begin
        @(posedge clk); #1;
        n++;
        if (get_sig(idx) !== prev) break;
        if (n > 2 * h + 10) break;
      end
      check($sformatf("%s half%0d", name, k), n, h);
      prev = get_sig(idx);
    end
  endtask

  task automatic run_vecs(input vec_t v[$], input string name);
    logic [7:0] e;
    foreach (v[i]) begin
      @(negedge clk);
      write         = v[i].wr;
      write_address = v[i].wa;
      write_value   = v[i].wv;
      read          = v[i].rd;
      read_address  = v[i].ra;
      if (v[i].chk) exp_q.push_back(v[i].exp);
      @(posedge clk); #1;
      if (v[i].chk) begin
        if (exp_q.size() == 0) check($sformatf("%s[%0d] queue", name, i), 0, 1);
        else begin
          e = exp_q.pop_front();
          check($sformatf("%s[%0d] data", name, i), data_m, e);
        end
      end
    end
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; write = 1'b0; write_address = '0; write_value = '0;
    read = 1'b0; read_address = '0;

    vecs.push_back(mk(1, 0, 'h11, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 'h22, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 'h33, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 'h44, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 'h11));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h22));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 'h33));
    vecs.push_back(mk(0, 0, 0, 1, 3, 1, 'h44));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h44));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h44));
    vecs.push_back(mk(1, 4, 'hAA, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4, 1, 'h00));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 'h11));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 'h22));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 'h33));
    vecs.push_back(mk(0, 0, 0, 1, 3, 1, 'h44));
    vecs.push_back(mk(0, 0, 0, 1, 63, 1, 'h00));
    vecs.push_back(mk(1, 2, 'h55, 1, 2, 1, 'h33));
    vecs.push_back(mk(0, 0, 0, 1, 2, 1, 'h55));
    vecs.push_back(mk(1, 63, 'h77, 1, 3, 1, 'h44));

    post_rst.push_back(mk(0, 0, 0, 1, 0, 1, 'h00));
    post_rst.push_back(mk(0, 0, 0, 1, 1, 1, 'h00));
    post_rst.push_back(mk(0, 0, 0, 1, 2, 1, 'h00));
    post_rst.push_back(mk(0, 0, 0, 1, 3, 1, 'h00));

    repeat (3) @(posedge clk);
    #1;
    check("rst bclk", bclk_m, 0);
    check("rst bclk_x8", bclk_x8_m, 0);
    check("rst slow_clk", slow_m, 0);
    check("rst data", data_m, 0);
    check("rst fast bclk", bclk_f, 0);
    check("rst fast slow_clk", slow_f, 0);
    @(negedge clk);
    rst = 1'b0;

    fork
      measure(0, 5208, 8, "bclk");
      measure(1, 651, 8, "bclk_x8");
      measure(2, 5, 6, "slow10");
      measure(3, 434, 4, "bclk_b3");
      measure(4, 54, 4, "bclk_x8_b3");
      measure(5, 1, 6, "slow2");
      run_vecs(vecs, "mem");
    join

    // Mid-count reset while bclk is high, with a write pending in the same cycle.
    n = 0;
    while (bclk_m !== 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("bclk high before midrst", bclk_m, 1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    write = 1'b1; write_address = 6'd0; write_value = 8'h99;
    @(posedge clk); #1;
    check("midrst bclk", bclk_m, 0);
    check("midrst bclk_x8", bclk_x8_m, 0);
    check("midrst slow_clk", slow_m, 0);
    check("midrst data", data_m, 0);
    @(negedge clk);
    rst = 1'b0;
    write = 1'b0;
    fork
      measure(0, 5208, 0, "bclk after midrst");
      measure(1, 651, 2, "bclk_x8 after midrst");
      run_vecs(post_rst, "cleared");
    join

    check("exp_q drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
